// File: rtl/vsfx_byte_pipe.sv
// Two-stage byte-wise add/subtract unit (modulo and unsigned-saturating) with valid/ready on both sides.
// Optional feature macro VSFX_SAT_EN: saturating ops, out_sat and sticky vscr_sat; otherwise ops 1x fold to modulo.
module vsfx_byte_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] vra,
  input  logic [31:0] vrb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] vrt,
  output logic        out_sat,
  input  logic        sat_clr,
  output logic        vscr_sat
);

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = DATA_W / LANE_W;

  logic              s1_valid_q, s1_valid_d;
  logic [1:0]        s1_op_q;
  logic [DATA_W-1:0] s1_vra_q;
  logic [DATA_W-1:0] s1_vrb_q;
  logic [DATA_W-1:0] s1_res;
  logic              s1_sat;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] vrt_q, vrt_d;
  logic              out_sat_q, out_sat_d;

  logic              s2_take;
  logic              in_fire;
  logic              s2_load;

`ifdef VSFX_SAT_EN
  // Returns {lane_sat, lane_result}; the 9th bit of sum/difference is carry/borrow.
  function automatic logic [LANE_W:0] lane_calc(input logic [1:0]        lop,
                                                input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
    logic [LANE_W:0] sum;
    logic [LANE_W:0] dif;
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    case (lop)
      2'b00:   lane_calc = {1'b0, sum[LANE_W-1:0]};
      2'b01:   lane_calc = {1'b0, dif[LANE_W-1:0]};
      2'b10:   lane_calc = sum[LANE_W] ? {1'b1, {LANE_W{1'b1}}} : {1'b0, sum[LANE_W-1:0]};
      default: lane_calc = dif[LANE_W] ? {1'b1, {LANE_W{1'b0}}} : {1'b0, dif[LANE_W-1:0]};
    endcase
  endfunction

  logic [LANES-1:0] lane_sat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign {lane_sat[g], s1_res[g*LANE_W +: LANE_W]} =
      lane_calc(s1_op_q, s1_vra_q[g*LANE_W +: LANE_W], s1_vrb_q[g*LANE_W +: LANE_W]);
  end

  assign s1_sat = |lane_sat;
`else
  function automatic logic [LANE_W-1:0] lane_calc(input logic              sub,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
    lane_calc = sub ? (a - b) : (a + b);
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign s1_res[g*LANE_W +: LANE_W] =
      lane_calc(s1_op_q[0], s1_vra_q[g*LANE_W +: LANE_W], s1_vrb_q[g*LANE_W +: LANE_W]);
  end

  assign s1_sat = 1'b0;

  // Only op[0] distinguishes add from subtract when saturation is compiled out.
  logic unused_op_hi;
  logic unused_sat_clr;
  assign unused_op_hi   = s1_op_q[1];
  assign unused_sat_clr = sat_clr;
`endif

  // Handshake: S2 can accept when empty or being drained; S1 when empty or advancing.
  assign s2_take  = !out_valid_q || out_ready;
  assign in_ready = rst_n && (!s1_valid_q || s2_take);
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s2_take && s1_valid_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    vrt_d       = vrt_q;
    out_sat_d   = out_sat_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s2_take) begin
      s1_valid_d = 1'b0;
    end
    if (s2_take) begin
      out_valid_d = s1_valid_q;
    end
    // Bubbles do not overwrite the result, so vrt keeps its last value when empty.
    if (s2_load) begin
      vrt_d     = s1_res;
      out_sat_d = s1_sat;
    end
  end

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op_q  <= op;
      s1_vra_q <= vra;
      s1_vrb_q <= vrb;
    end
  end

  // Stage 2: registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      vrt_q       <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      vrt_q       <= vrt_d;
      out_sat_q   <= out_sat_d;
    end
  end

`ifdef VSFX_SAT_EN
  logic vscr_sat_q, vscr_sat_d;

  // Setting on a saturating load takes priority over a same-cycle clear.
  always_comb begin
    vscr_sat_d = vscr_sat_q;
    if (s2_load && s1_sat) begin
      vscr_sat_d = 1'b1;
    end else if (sat_clr) begin
      vscr_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vscr_sat_q <= 1'b0;
    end else begin
      vscr_sat_q <= vscr_sat_d;
    end
  end

  assign vscr_sat = vscr_sat_q;
`else
  assign vscr_sat = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign vrt       = vrt_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/vsfx_byte_pipe.md
# vsfx_byte_pipe

Pipelined byte-wise simple fixed-point unit for the VSFX cluster. Accepts one 32-bit vector operand pair per cycle from the issue stage over a valid/ready handshake. Computes one of four unsigned-byte add/subtract operations, with the `vsububm` modulo subtract among them. Returns the registered result to the writeback stage over a second valid/ready handshake and keeps a sticky saturation flag (VSCR[SAT] equivalent).

## Interface
Parameters:
- none (lane count fixed: 4 bytes in 32 bits)

Ports:
- `clk`  in  1  — single clock, all state on rising edge
- `rst_n`  in  1  — synchronous, active-low reset
- `in_valid`  in  1  — operand pair valid
- `in_ready`  out  1  — unit can accept operands this cycle
- `op`  in  2  — 00 vaddubm, 01 vsububm, 10 vaddubs, 11 vsububs
- `vra`  in  32  — operand A, byte 3 = [31:24] … byte 0 = [7:0]
- `vrb`  in  32  — operand B, same byte order
- `out_valid`  out  1  — result valid
- `out_ready`  in  1  — writeback can take result
- `vrt`  out  32  — result vector
- `out_sat`  out  1  — any lane of this result saturated
- `sat_clr`  in  1  — clear sticky flag
- `vscr_sat`  out  1  — sticky saturation flag

## Operation
- Two register stages:
  - S1 holds {`op`, `vra`, `vrb`, `s1_valid`}.
  - S2 holds {`vrt`, `out_sat`, `out_valid`}.
- Arithmetic is per 8-bit lane and independent; no carries cross lanes.
  - Modulo ops: the result is the low 8 bits of a±b.
  - vaddubs: a+b>255 → 0xFF, lane sat=1.
  - vsububs: a<b → 0x00, lane sat=1.
  - `out_sat` is the OR of all four lane sat bits.
  - Modulo ops always give `out_sat`=0.
- Advance rules:
  - `s2_take = !out_valid || out_ready`.
  - `in_ready = rst_n && (!s1_valid || s2_take)`.
  - On an S1 transfer (`in_valid && in_ready`), S1 loads the inputs and `s1_valid`←1. Otherwise, if `s2_take`, `s1_valid`←0.
  - If `s2_take`, S2 loads the S1 result and `out_valid`←`s1_valid`. Otherwise S2 holds.
- `vrt`/`out_sat` are stable while `out_valid && !out_ready`. No result is dropped or duplicated.
- Sticky flag:
  - `vscr_sat`←1 when S2 loads a result with `out_sat`=1 (`s2_take && s1_valid && s1_sat`).
  - Otherwise `sat_clr` clears it.
  - Set and clear in the same cycle → set wins.
- Reset (`rst_n`=0 at an edge):
  - `s1_valid`, `out_valid`, `vrt`, `out_sat` and `vscr_sat` all go to 0.
  - `in_ready`=0 while `rst_n` is low.
  - In-flight operations are discarded.

## Timing
- Latency: operands accepted at edge N → `out_valid`=1 with the result after edge N+1, i.e. 2 cycles.
- Throughput is 1 op/cycle when `out_ready`=1.
- Stall: with `out_ready`=0 and both stages full, `in_ready`=0 in the same cycle (combinational from state and `out_ready`).
  - Up to 2 ops are buffered.
  - After `out_ready` returns high, results drain in order on consecutive cycles.
- Simultaneous handshakes: an input accept and an output consume in the same cycle are legal when full; occupancy stays 2.
- Empty pipe: `out_valid`=0 and `vrt` holds its last value. Consumers qualify `vrt` with `out_valid`.
- Outputs are registered, except `in_ready`.

## Configuration
- `VSFX_SAT_EN`
  - Defined: all four ops as above; `out_sat` and `vscr_sat` are live.
  - Undefined:
    - op 10 executes as vaddubm and op 11 as vsububm.
    - `out_sat` and `vscr_sat` are tied to 0; `sat_clr` is ignored.
    - Saturation logic and the sticky register are not synthesised.

## Test plan
- vsububm: `vra`=00010203, `vrb`=04040404 → after 2 cycles `vrt`=FCFDFEFF, `out_sat`=0.
- vsububs: `vra`=FE00FF00, `vrb`=0001FF01 → `vrt`=FE000000, `out_sat`=1, `vscr_sat`=1 next cycle. Then pulse `sat_clr` → `vscr_sat`=0.
- vaddubs: `vra`=FEDCBA98, `vrb`=01234567 → `vrt`=FFFFFFFF, `out_sat`=0. Then FF000000+01000000 → FF000000, `out_sat`=1.
- Back-pressure: issue 3 back-to-back vaddubm ops with `out_ready`=0 → `in_ready` drops after the 2nd accept. Raise `out_ready` → all 3 results return in order, with none lost and none duplicated.
- Sticky set vs clear: `sat_clr`=1 in the same cycle a saturating result loads S2 → `vscr_sat`=1.
- Mid-operation reset: `rst_n`=0 for 1 cycle with both stages full → `out_valid`=0 and `vscr_sat`=0 the next cycle, and no stale result appears afterwards. Without `VSFX_SAT_EN`, op 11 on 00000000-01010101 → FFFFFFFF, `out_sat`=0.
